dcsk_rx_correlator: RTL and testbench

Receive-side counterpart of the DCSK transmit serializer. It accepts a stream of signed received chips. Each symbol is SPREAD_FACTOR reference chips followed by SPREAD_FACTOR data chips. The block buffers the reference half, correlates the data half against it chip by chip, and emits one hard-decided bit per symbol. It sits between the channel front end (ADC/sampler) and the bit sink.

---
 rtl/dcsk_rx_correlator.sv | 112 +++++++++++
 tb/tb_dcsk_rx_correlator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcsk_rx_correlator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcsk_rx_correlator                                           |
// | Description : DCSK receive correlator. Buffers the reference half-symbol,  |
// |               correlates the data half against it and emits a hard bit.    |
// |               Optional macro DCSK_CORR_OUT_EN exposes the correlation sum. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dcsk_rx_correlator #(
  parameter int SPREAD_FACTOR = 2,
  parameter int CHIP_W        = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    chip_valid,
  input  logic signed [CHIP_W-1:0]                chip_in,
  input  logic                                    frame_start,
  output logic [$clog2(2*SPREAD_FACTOR)-1:0]      chip_index,
  output logic                                    bit_valid,
  output logic                                    bit_out,
  output logic                                    busy
`ifdef DCSK_CORR_OUT_EN
  ,
  output logic signed [2*CHIP_W+$clog2(SPREAD_FACTOR):0] corr_out
`endif
);

  localparam int ACC_W     = 2*CHIP_W + $clog2(SPREAD_FACTOR) + 1;
  localparam int PROD_W    = 2*CHIP_W;
  localparam int IDX_W     = $clog2(2*SPREAD_FACTOR);
  localparam int REF_IDX_W = $clog2(SPREAD_FACTOR);

  localparam logic [IDX_W-1:0] C_REF_LAST  = IDX_W'(SPREAD_FACTOR - 1);
  localparam logic [IDX_W-1:0] C_DATA_LAST = IDX_W'(2*SPREAD_FACTOR - 1);
  localparam logic [IDX_W-1:0] C_SF        = IDX_W'(SPREAD_FACTOR);
  localparam logic [IDX_W-1:0] C_ONE       = IDX_W'(1);

  localparam logic [0:0] ST_REF  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]               r_state;
  logic signed [CHIP_W-1:0] r_ref_buf [SPREAD_FACTOR];
  logic signed [ACC_W-1:0]  r_acc;

  logic [REF_IDX_W-1:0]     w_ref_wr_idx;
  logic [REF_IDX_W-1:0]     w_data_idx;
  logic signed [CHIP_W-1:0] w_ref_sel;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;

  assign w_ref_wr_idx = REF_IDX_W'(chip_index);
  assign w_data_idx   = REF_IDX_W'(chip_index - C_SF);
  assign w_ref_sel    = r_ref_buf[w_data_idx];
  // Size casts of signed operands sign-extend, giving a full-width signed product.
  assign w_prod       = PROD_W'(chip_in) * PROD_W'(w_ref_sel);
  assign w_sum        = r_acc + ACC_W'(w_prod);
  assign busy         = (chip_index != '0);

  // Reference storage needs no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (chip_valid) begin
      if (frame_start) begin
        r_ref_buf[0] <= chip_in;
      end else if (r_state == ST_REF) begin
        r_ref_buf[w_ref_wr_idx] <= chip_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_REF;
      chip_index <= '0;
      r_acc      <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
`ifdef DCSK_CORR_OUT_EN
      corr_out   <= '0;
`endif
    end else begin
      bit_valid <= 1'b0;
      if (chip_valid) begin
        if (frame_start) begin
          // Resynchronise: discards any partial symbol, including one on its last chip.
          r_state    <= ST_REF;
          chip_index <= C_ONE;
        end else if (r_state == ST_REF) begin
          if (chip_index == C_REF_LAST) begin
            r_state <= ST_DATA;
            r_acc   <= '0;
          end
          chip_index <= chip_index + C_ONE;
        end else begin
          if (chip_index == C_DATA_LAST) begin
            r_state    <= ST_REF;
            chip_index <= '0;
            bit_valid  <= 1'b1;
            bit_out    <= ~w_sum[ACC_W-1];
`ifdef DCSK_CORR_OUT_EN
            corr_out   <= w_sum;
`endif
          end else begin
            r_acc      <= w_sum;
            chip_index <= chip_index + C_ONE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcsk_rx_correlator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dcsk_rx_correlator                                        |
// | Description : Directed self-checking bench for dcsk_rx_correlator (SF=2/4) |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dcsk_rx_correlator;

  logic clk;
  logic rst;

  logic              a_valid, a_fs;
  logic signed [7:0] a_chip;
  logic [1:0]        a_idx;
  logic              a_bv, a_bo, a_busy;

  logic              b_valid, b_fs;
  logic signed [7:0] b_chip;
  logic [2:0]        b_idx;
  logic              b_bv, b_bo, b_busy;

`ifdef DCSK_CORR_OUT_EN
  logic signed [17:0] a_corr;
  logic signed [18:0] b_corr;
`endif

  int n_vec = 0;
  int n_err = 0;

  dcsk_rx_correlator #(.SPREAD_FACTOR(2), .CHIP_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .chip_valid(a_valid), .chip_in(a_chip),
    .frame_start(a_fs), .chip_index(a_idx), .bit_valid(a_bv),
    .bit_out(a_bo), .busy(a_busy)
`ifdef DCSK_CORR_OUT_EN
    , .corr_out(a_corr)
`endif
  );

  dcsk_rx_correlator #(.SPREAD_FACTOR(4), .CHIP_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .chip_valid(b_valid), .chip_in(b_chip),
    .frame_start(b_fs), .chip_index(b_idx), .bit_valid(b_bv),
    .bit_out(b_bo), .busy(b_busy)
`ifdef DCSK_CORR_OUT_EN
    , .corr_out(b_corr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int c, input bit fs);
    a_valid = 1'b1;
    a_chip  = 8'(c);
    a_fs    = fs;
    tick(1);
    a_valid = 1'b0;
    a_fs    = 1'b0;
  endtask

  task automatic send_b(input int c);
    b_valid = 1'b1;
    b_chip  = 8'(c);
    tick(1);
    b_valid = 1'b0;
  endtask

  task automatic expect_a_bit(input string tag, input bit bo, input int corr);
    check({tag, "_bv"}, 32'(a_bv), 1);
    check({tag, "_bo"}, 32'(a_bo), 32'(bo));
    check({tag, "_idx"}, 32'(a_idx), 0);
`ifdef DCSK_CORR_OUT_EN
    check({tag, "_corr"}, 32'(a_corr), corr);
`else
    if (corr == 0) begin end
`endif
    tick(1);
    check({tag, "_bv_pulse"}, 32'(a_bv), 0);
    check({tag, "_bo_hold"}, 32'(a_bo), 32'(bo));
  endtask

  task automatic expect_b_bit(input string tag, input bit bo, input int corr);
    check({tag, "_bv"}, 32'(b_bv), 1);
    check({tag, "_bo"}, 32'(b_bo), 32'(bo));
    check({tag, "_idx"}, 32'(b_idx), 0);
`ifdef DCSK_CORR_OUT_EN
    check({tag, "_corr"}, 32'(b_corr), corr);
`else
    if (corr == 0) begin end
`endif
    tick(1);
    check({tag, "_bv_pulse"}, 32'(b_bv), 0);
  endtask

  initial begin
    int c4[4];
    rst = 1'b1;
    a_valid = 1'b0; a_fs = 1'b0; a_chip = '0;
    b_valid = 1'b0; b_fs = 1'b0; b_chip = '0;
    tick(2);

    check("rst_idx", 32'(a_idx), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_bv", 32'(a_bv), 0);
    check("rst_bo", 32'(a_bo), 0);
`ifdef DCSK_CORR_OUT_EN
    check("rst_corr", 32'(a_corr), 0);
`endif
    rst = 1'b0;
    tick(1);

    // Back-to-back symbol with frame_start on its first chip: 25 + 9
    send_a(5, 1'b1);
    check("t1_idx1", 32'(a_idx), 1);
    check("t1_busy1", 32'(a_busy), 1);
    send_a(-3, 1'b0);
    check("t1_idx2", 32'(a_idx), 2);
    send_a(5, 1'b0);
    check("t1_idx3", 32'(a_idx), 3);
    check("t1_nobit", 32'(a_bv), 0);
    send_a(-3, 1'b0);
    expect_a_bit("t1", 1'b1, 34);

    // Gapped symbol: -25 - 9
    c4 = '{5, -3, -5, 3};
    for (int i = 0; i < 4; i++) begin
      send_a(c4[i], 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          check("t2_busy", 32'(a_busy), 1);
          check("t2_nobit", 32'(a_bv), 0);
          tick(1);
        end
      end
    end
    expect_a_bit("t2", 1'b0, -34);
    check("t2_idle_busy", 32'(a_busy), 0);

    // Zero correlation decides 1
    c4 = '{7, 2, 0, 0};
    for (int i = 0; i < 3; i++) send_a(c4[i], 1'b0);
    send_a(c4[3], 1'b0);
    expect_a_bit("t3a", 1'b1, 0);
    c4 = '{1, 1, 1, -1};
    for (int i = 0; i < 4; i++) send_a(c4[i], 1'b0);
    expect_a_bit("t3b", 1'b1, 0);

    // Mid-symbol frame_start aborts the partial symbol
    send_a(5, 1'b0);
    send_a(-3, 1'b0);
    send_a(5, 1'b0);
    send_a(2, 1'b1);
    check("t5_restart_idx", 32'(a_idx), 1);
    check("t5_nobit0", 32'(a_bv), 0);
    send_a(1, 1'b0);
    send_a(2, 1'b0);
    check("t5_nobit1", 32'(a_bv), 0);
    send_a(1, 1'b0);
    expect_a_bit("t5", 1'b1, 5);

    // frame_start on the last data chip wins: ref 9,1 data -2,1 -> -17
    send_a(3, 1'b0);
    send_a(3, 1'b0);
    send_a(3, 1'b0);
    send_a(9, 1'b1);
    check("t5b_nobit", 32'(a_bv), 0);
    check("t5b_idx", 32'(a_idx), 1);
    send_a(1, 1'b0);
    send_a(-2, 1'b0);
    send_a(1, 1'b0);
    expect_a_bit("t5b", 1'b0, -17);

    // frame_start without chip_valid is ignored
    a_fs = 1'b1;
    tick(1);
    a_fs = 1'b0;
    check("t5c_idx", 32'(a_idx), 0);

    // Reset after the third chip discards the symbol
    send_a(5, 1'b0);
    send_a(-3, 1'b0);
    send_a(5, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_idx", 32'(a_idx), 0);
    check("t6_rst_bv", 32'(a_bv), 0);
    check("t6_rst_busy", 32'(a_busy), 0);
    c4 = '{4, 4, -4, -4};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check("t6_nobit", 32'(a_bv), 0);
      send_a(c4[i], 1'b0);
    end
    expect_a_bit("t6", 1'b0, -32);

    // Reset coinciding with the last data chip suppresses its decision
    send_a(1, 1'b0);
    send_a(1, 1'b0);
    send_a(1, 1'b0);
    rst = 1'b1;
    a_valid = 1'b1;
    a_chip = 8'sd1;
    tick(1);
    rst = 1'b0;
    a_valid = 1'b0;
    check("t7_bv", 32'(a_bv), 0);
    check("t7_idx", 32'(a_idx), 0);
    tick(1);
    check("t7_bv_late", 32'(a_bv), 0);

    // SF=4 extremes: 4 * 16384 and 4 * (-16256)
    for (int i = 0; i < 8; i++) begin
      send_b(-128);
      if (i < 7) check("t4a_idx", 32'(b_idx), i + 1);
    end
    expect_b_bit("t4a", 1'b1, 65536);
    for (int i = 0; i < 8; i++) send_b(i < 4 ? -128 : 127);
    expect_b_bit("t4b", 1'b0, -65024);
    check("t4b_busy", 32'(b_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
